// File: rtl/mem_access_unit.sv
// MEM stage: EX/MEM controls -> data-memory req/ack transaction, load align/extend, MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and reported on bus_err_out.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [1:0]  MemtoReg,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic [31:0] result,
  input  logic [31:0] writeData,
  input  logic [31:0] NextAddr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        RegWrite_out,
  output logic [1:0]  MemtoReg_out,
  output logic [4:0]  rd_out,
  output logic [31:0] result_out,
  output logic [31:0] NextAddr_out,
  output logic [31:0] readData_out,
  output logic        bus_err_out
);
  typedef enum logic {IDLE, WAIT} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t      state;
  logic [CW-1:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        we_q;

  logic        access, is_load, is_byte, is_half, is_word, misalign;
  logic [1:0]  off;
  logic [3:0]  be_live;
  logic [31:0] wdata_live, rsh, load_data;
  logic        issue, timeout_hit, ack_ok;

  assign access  = MemRead | MemWrite;
  assign is_load = MemRead;
  assign off     = result[1:0];
  // Unused funct3 encodings fall through to word size.
  assign is_byte = is_load ? (funct3[1:0] == 2'b00) : (funct3 == 3'b000);
  assign is_half = is_load ? (funct3[1:0] == 2'b01) : (funct3 == 3'b001);
  assign is_word = !is_byte && !is_half;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = access && ((is_half && off[0]) || (is_word && off != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    be_live    = 4'hF;
    wdata_live = writeData;
    if (is_byte) begin
      be_live    = 4'b0001 << off;
      wdata_live = {4{writeData[7:0]}};
    end else if (is_half) begin
      be_live    = 4'b0011 << off;
      wdata_live = {2{writeData[15:0]}};
    end
  end

  assign rsh = dmem_rdata >> {off, 3'b000};
  always_comb begin
    load_data = dmem_rdata;
    if (is_byte)      load_data = {{24{rsh[7]  & ~funct3[2]}}, rsh[7:0]};
    else if (is_half) load_data = {{16{rsh[15] & ~funct3[2]}}, rsh[15:0]};
  end

  assign issue       = (state == IDLE) && access && !misalign;
  assign timeout_hit = (state == WAIT) && (cnt == TMO);
  // Gated by rst so the request drops the instant reset asserts.
  assign dmem_req    = !rst && (issue || (state == WAIT && !timeout_hit));
  assign ack_ok      = dmem_req && dmem_ack;
  assign stall_out   = dmem_req && !dmem_ack;

  always_comb begin
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    if (dmem_req) begin
      if (state == WAIT) begin
        dmem_we = we_q; dmem_addr = addr_q; dmem_wdata = wdata_q; dmem_be = be_q;
      end else begin
        dmem_we = MemWrite && !MemRead; dmem_addr = {result[31:2], 2'b00};
        dmem_wdata = wdata_live; dmem_be = be_live;
      end
    end
  end

  // Next MEM/WB contents; default is a bubble.
  logic        n_rw, n_err, pass;
  logic [31:0] n_rdata;
  always_comb begin
    pass    = 1'b0;
    n_rw    = 1'b0;
    n_rdata = '0;
    n_err   = 1'b0;
    if (state == IDLE && !access) begin
      pass = 1'b1; n_rw = RegWrite;
    end else if (state == IDLE && misalign) begin
      pass = 1'b1; n_err = 1'b1;
    end else if (timeout_hit) begin
      pass = 1'b1; n_err = 1'b1;
    end else if (ack_ok) begin
      pass = 1'b1; n_rw = RegWrite;
      n_rdata = is_load ? load_data : 32'h0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      we_q         <= 1'b0;
      RegWrite_out <= 1'b0;
      MemtoReg_out <= '0;
      rd_out       <= '0;
      result_out   <= '0;
      NextAddr_out <= '0;
      readData_out <= '0;
      bus_err_out  <= 1'b0;
    end else begin
      RegWrite_out <= n_rw;
      MemtoReg_out <= pass ? MemtoReg : 2'b00;
      rd_out       <= pass ? rd       : 5'd0;
      result_out   <= pass ? result   : 32'h0;
      NextAddr_out <= pass ? NextAddr : 32'h0;
      readData_out <= n_rdata;
      bus_err_out  <= n_err;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (issue) begin
            addr_q  <= {result[31:2], 2'b00};
            wdata_q <= wdata_live;
            be_q    <= be_live;
            we_q    <= MemWrite && !MemRead;
            if (!dmem_ack) begin
              state <= WAIT;
              cnt   <= CW'(1);
            end
          end
        end
        WAIT: begin
          if (timeout_hit || dmem_ack) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT=4): table of single-cycle accesses plus wait/timeout/reset sequences.
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic RegWrite = 1'b0, MemWrite = 1'b0, MemRead = 1'b0;
  logic [1:0]  MemtoReg = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] result = '0, writeData = '0, NextAddr = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_req, dmem_we, stall_out, RegWrite_out, bus_err_out;
  logic [31:0] dmem_addr, dmem_wdata, result_out, NextAddr_out, readData_out;
  logic [3:0]  dmem_be;
  logic [1:0]  MemtoReg_out;
  logic [4:0]  rd_out;

  int errors = 0, checks = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .funct3(funct3), .rd(rd), .result(result), .writeData(writeData),
    .NextAddr(NextAddr), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .rd_out(rd_out), .result_out(result_out), .NextAddr_out(NextAddr_out),
    .readData_out(readData_out), .bus_err_out(bus_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rw, mw, mr; logic [1:0] mtr; logic [2:0] f3; logic [4:0] rd;
    logic [31:0] res, wd, na; logic ack; logic [31:0] rdata;
    logic e_req, e_we; logic [31:0] e_addr, e_wdata; logic [3:0] e_be; logic e_stall;
    logic e_rw; logic [1:0] e_mtr; logic [31:0] e_rdata; logic e_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic rw, mw, mr, input logic [1:0] mtr, input logic [2:0] f3,
                        input logic [4:0] rdv, input logic [31:0] res, wd, na);
    RegWrite = rw; MemWrite = mw; MemRead = mr; MemtoReg = mtr; funct3 = f3;
    rd = rdv; result = res; writeData = wd; NextAddr = na;
  endtask

  // Load that waits `waits` stall cycles before ack.
  task automatic load_wait(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                           input int waits, input logic [31:0] rdata, input logic [31:0] exp);
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 2'd1, f3, 5'd9, addr, 32'h0, 32'h20);
    dmem_ack = 1'b0;
    for (int c = 0; c < waits; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk({nm, " stall"}, stall_out, 1'b1);
      chk({nm, " wait addr"}, dmem_addr, {addr[31:2], 2'b00});
      @(posedge clk); #1;
      chk({nm, " bubble rw"}, RegWrite_out, 1'b0);
    end
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    chk({nm, " done stall"}, stall_out, 1'b0);
    chk({nm, " done req"}, dmem_req, 1'b1);
    @(posedge clk); #1;
    chk({nm, " rdata"}, readData_out, exp);
    chk({nm, " rw"}, RegWrite_out, 1'b1);
    chk({nm, " rd"}, rd_out, 5'd9);
    chk({nm, " err"}, bus_err_out, 1'b0);
    @(negedge clk);
    dmem_ack = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b1,1'b0,1'b0,2'd0,3'd0,5'd5,32'h1234,32'h0,32'h8,1'b1,32'hFFFFFFFF,
                 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,2'd0,32'h0,1'b0};
    vecs[1]  = '{1'b1,1'b0,1'b1,2'd1,3'b010,5'd6,32'h100,32'h0,32'hC,1'b1,32'hDEADBEEF,
                 1'b1,1'b0,32'h100,32'h0,4'hF,1'b0, 1'b1,2'd1,32'hDEADBEEF,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b0,2'd0,3'b001,5'd0,32'h202,32'h0000ABCD,32'h10,1'b1,32'h0,
                 1'b1,1'b1,32'h200,32'hABCDABCD,4'hC,1'b0, 1'b0,2'd0,32'h0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,2'd0,3'b000,5'd0,32'h301,32'h0000005A,32'h14,1'b1,32'h0,
                 1'b1,1'b1,32'h300,32'h5A5A5A5A,4'h2,1'b0, 1'b0,2'd0,32'h0,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b1,2'd1,3'b001,5'd7,32'h402,32'h0,32'h18,1'b1,32'h80017FFF,
                 1'b1,1'b0,32'h400,32'h0,4'hC,1'b0, 1'b1,2'd1,32'hFFFF8001,1'b0};
    vecs[5]  = '{1'b1,1'b0,1'b1,2'd1,3'b101,5'd7,32'h402,32'h0,32'h18,1'b1,32'h80017FFF,
                 1'b1,1'b0,32'h400,32'h0,4'hC,1'b0, 1'b1,2'd1,32'h00008001,1'b0};
    vecs[6]  = '{1'b1,1'b0,1'b1,2'd1,3'b100,5'd8,32'h101,32'h0,32'h1C,1'b1,32'h11223344,
                 1'b1,1'b0,32'h100,32'h0,4'h2,1'b0, 1'b1,2'd1,32'h00000033,1'b0};
    vecs[7]  = '{1'b0,1'b1,1'b0,2'd0,3'b010,5'd0,32'h504,32'hCAFEF00D,32'h20,1'b1,32'h0,
                 1'b1,1'b1,32'h504,32'hCAFEF00D,4'hF,1'b0, 1'b0,2'd0,32'h0,1'b0};
    vecs[8]  = '{1'b1,1'b0,1'b1,2'd1,3'b000,5'd3,32'h500,32'h0,32'h24,1'b1,32'h0000007F,
                 1'b1,1'b0,32'h500,32'h0,4'h1,1'b0, 1'b1,2'd1,32'h0000007F,1'b0};
    vecs[9]  = '{1'b1,1'b0,1'b0,2'd2,3'd0,5'd1,32'h0,32'h0,32'h44,1'b0,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b1,2'd2,32'h0,1'b0};
    vecs[10] = '{1'b1,1'b1,1'b1,2'd1,3'b010,5'd4,32'h700,32'h00000099,32'h28,1'b1,32'h12345678,
                 1'b1,1'b0,32'h700,32'h00000099,4'hF,1'b0, 1'b1,2'd1,32'h12345678,1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[11] = '{1'b1,1'b0,1'b1,2'd1,3'b010,5'd2,32'h101,32'h0,32'h2C,1'b1,32'h0BADF00D,
                 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,2'd1,32'h0,1'b1};
    vecs[12] = '{1'b0,1'b1,1'b0,2'd0,3'b001,5'd0,32'h203,32'h1111BEEF,32'h30,1'b1,32'h0,
                 1'b0,1'b0,32'h0,32'h0,4'h0,1'b0, 1'b0,2'd0,32'h0,1'b1};
`else
    vecs[11] = '{1'b1,1'b0,1'b1,2'd1,3'b010,5'd2,32'h101,32'h0,32'h2C,1'b1,32'h0BADF00D,
                 1'b1,1'b0,32'h100,32'h0,4'hF,1'b0, 1'b1,2'd1,32'h0BADF00D,1'b0};
    vecs[12] = '{1'b0,1'b1,1'b0,2'd0,3'b001,5'd0,32'h203,32'h1111BEEF,32'h30,1'b1,32'h0,
                 1'b1,1'b1,32'h200,32'hBEEFBEEF,4'h8,1'b0, 1'b0,2'd0,32'h0,1'b0};
`endif

    // Reset state
    #2;
    chk("rst req", dmem_req, 1'b0);
    chk("rst stall", stall_out, 1'b0);
    chk("rst rw", RegWrite_out, 1'b0);
    chk("rst result", result_out, 32'h0);
    chk("rst rdata", readData_out, 32'h0);
    chk("rst err", bus_err_out, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      set_in(vecs[i].rw, vecs[i].mw, vecs[i].mr, vecs[i].mtr, vecs[i].f3, vecs[i].rd,
             vecs[i].res, vecs[i].wd, vecs[i].na);
      dmem_ack = vecs[i].ack; dmem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d req", i), dmem_req, vecs[i].e_req);
      chk($sformatf("v%0d we", i), dmem_we, vecs[i].e_we);
      chk($sformatf("v%0d addr", i), dmem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d wdata", i), dmem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d be", i), dmem_be, vecs[i].e_be);
      chk($sformatf("v%0d stall", i), stall_out, vecs[i].e_stall);
      @(posedge clk); #1;
      chk($sformatf("v%0d rw_out", i), RegWrite_out, vecs[i].e_rw);
      chk($sformatf("v%0d mtr_out", i), MemtoReg_out, vecs[i].e_mtr);
      chk($sformatf("v%0d rd_out", i), rd_out, vecs[i].rd);
      chk($sformatf("v%0d result_out", i), result_out, vecs[i].res);
      chk($sformatf("v%0d next_out", i), NextAddr_out, vecs[i].na);
      chk($sformatf("v%0d rdata_out", i), readData_out, vecs[i].e_rdata);
      chk($sformatf("v%0d err", i), bus_err_out, vecs[i].e_err);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);

    // Wait-state loads, and ack in the last permitted cycle
    load_wait("lb2", 3'b000, 32'h103, 2, 32'h80112233, 32'hFFFFFF80);
    load_wait("lbu2", 3'b100, 32'h103, 2, 32'h80112233, 32'h00000080);
    load_wait("lw_edge", 3'b010, 32'h800, 3, 32'h000055AA, 32'h000055AA);

    // Timeout: never ack
    begin
      int stalls = 0;
      bit done = 0;
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd12, 32'h600, 32'h0, 32'h40);
      for (int c = 0; c < 10 && !done; c++) begin
        if (c > 0) @(negedge clk);
        #1;
        if (stall_out) begin
          stalls++;
          @(posedge clk); #1;
          chk("to bubble err", bus_err_out, 1'b0);
        end else begin
          chk("to req drop", dmem_req, 1'b0);
          @(posedge clk); #1;
          chk("to err pulse", bus_err_out, 1'b1);
          chk("to rw", RegWrite_out, 1'b0);
          chk("to rdata", readData_out, 32'h0);
          chk("to rd", rd_out, 5'd12);
          done = 1;
        end
      end
      chk("to finished", done, 1'b1);
      chk("to stall cycles", stalls, 32'd4);
      @(negedge clk);
      set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd13, 32'h77, 32'h0, 32'h0);
      #1;
      chk("post-to stall", stall_out, 1'b0);
      @(posedge clk); #1;
      chk("post-to err", bus_err_out, 1'b0);
      chk("post-to rw", RegWrite_out, 1'b1);
      chk("post-to result", result_out, 32'h77);
    end

    // Reset asserted mid-WAIT
    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 2'd1, 3'b010, 5'd14, 32'h900, 32'h0, 32'h0);
    @(negedge clk); #1;
    chk("pre-rst stall", stall_out, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid-rst req", dmem_req, 1'b0);
    chk("mid-rst stall", stall_out, 1'b0);
    chk("mid-rst addr", dmem_addr, 32'h0);
    chk("mid-rst rw", RegWrite_out, 1'b0);
    chk("mid-rst err", bus_err_out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 5'd15, 32'h88, 32'h0, 32'h0);
    #1;
    chk("post-rst stall", stall_out, 1'b0);
    @(posedge clk); #1;
    chk("post-rst err", bus_err_out, 1'b0);
    chk("post-rst result", result_out, 32'h88);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
